// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_writer
// Brief    : Write side of the 4-bit framebuffer link. Buffers gray pixels
//            from the pixel engine in a small FIFO and hands them to the
//            RP2040 one nibble at a time using a toggle-strobe / echo-ack
//            handshake. Pulses the RP2040 write-pointer reset at each frame
//            start and flags completion of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module fb_pixel_writer #(
    parameter int FRAME_PIXELS     = 76800,
    parameter int FIFO_DEPTH       = 4,
    parameter int HOLD_CYCLES      = 4,
    parameter int PTR_RESET_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start_in,
    input  logic [3:0] pixel_in,
    input  logic       pixel_valid_in,
    output logic       pixel_ready_out,
    output logic [3:0] wr_nibble_out,
    output logic       wr_strobe_out,
    output logic       wr_reset_ptr_out,
    input  logic       wr_ack_in,
    output logic       busy_out,
    output logic       frame_done_out
);

    localparam int c_cnt_w  = $clog2(FRAME_PIXELS + 1);
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_hcnt_w = $clog2(HOLD_CYCLES + 1);
    localparam int c_pcnt_w = $clog2(PTR_RESET_CYCLES + 1);

    localparam logic [c_cnt_w-1:0]  c_frame_pixels = c_cnt_w'(FRAME_PIXELS);
    localparam logic [c_cnt_w-1:0]  c_cnt_one      = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one      = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0]  c_lvl_one      = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0]  c_lvl_full     = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_hcnt_w-1:0] c_hcnt_one     = c_hcnt_w'(1);
    localparam logic [c_hcnt_w-1:0] c_hold_min     = c_hcnt_w'(HOLD_CYCLES);
    localparam logic [c_pcnt_w-1:0] c_pcnt_one     = c_pcnt_w'(1);
    localparam logic [c_pcnt_w-1:0] c_ptr_last     = c_pcnt_w'(PTR_RESET_CYCLES - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_ptr_rst = 3'd1;
    localparam logic [2:0] c_st_send    = 3'd2;
    localparam logic [2:0] c_st_toggle  = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    logic [3:0]          r_fifo_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_lvl_w-1:0]  r_fifo_lvl;

    logic [c_cnt_w-1:0]  r_accepted;
    logic [c_cnt_w-1:0]  r_sent;
    logic [c_hcnt_w-1:0] r_hold_cnt;
    logic [c_pcnt_w-1:0] r_ptr_cnt;
    logic [3:0]          r_nibble;
    logic                r_strobe;

    logic                w_fifo_nempty;
    logic                w_fifo_full;
    logic                w_room;
    logic                w_push;
    logic                w_pop;
    logic                w_hold_ok;
    logic [c_cnt_w-1:0]  w_sent_inc;

    assign w_fifo_nempty = (r_fifo_lvl != '0);
    assign w_fifo_full   = (r_fifo_lvl == c_lvl_full);
    assign w_room        = (r_accepted < c_frame_pixels);
    assign w_push        = pixel_valid_in & pixel_ready_out;
    // A pop only uses data already present at the start of the cycle, and a
    // frame restart flushes instead of popping.
    assign w_pop         = (r_state == c_st_send) & w_fifo_nempty & ~frame_start_in;
    // The strobe level must be held long enough for PIO sampling and the
    // receiver must have echoed it before the next nibble may go out.
    assign w_hold_ok     = (r_hold_cnt >= c_hold_min) & (wr_ack_in == r_strobe);
    assign w_sent_inc    = r_sent + c_cnt_one;

    assign wr_nibble_out = r_nibble;
    assign wr_strobe_out = r_strobe;

    // FIFO storage write; pointers and level live in the control block below.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= pixel_in;
        end
    end

    // FIFO pointers, fill level and per-frame accepted count.
    always_ff @(posedge clk) begin
        if (rst || frame_start_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_lvl <= '0;
            r_accepted <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + c_ptr_one;
                r_accepted <= r_accepted + c_cnt_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_lvl <= r_fifo_lvl + c_lvl_one;
                2'b01:   r_fifo_lvl <= r_fifo_lvl - c_lvl_one;
                default: r_fifo_lvl <= r_fifo_lvl;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs; a frame start wins everywhere.
    always_comb begin
        w_state_nxt      = r_state;
        pixel_ready_out  = 1'b0;
        wr_reset_ptr_out = 1'b0;
        busy_out         = (r_state != c_st_idle);
        frame_done_out   = 1'b0;

        case (r_state)
            c_st_ptr_rst: begin
                wr_reset_ptr_out = 1'b1;
                pixel_ready_out  = ~w_fifo_full & w_room;
                if (r_ptr_cnt == c_ptr_last) begin
                    w_state_nxt = c_st_send;
                end
            end
            c_st_send: begin
                pixel_ready_out = ~w_fifo_full & w_room;
                if (w_fifo_nempty) begin
                    w_state_nxt = c_st_toggle;
                end
            end
            c_st_toggle: begin
                pixel_ready_out = ~w_fifo_full & w_room;
                w_state_nxt     = c_st_hold;
            end
            c_st_hold: begin
                pixel_ready_out = ~w_fifo_full & w_room;
                if (w_hold_ok) begin
                    w_state_nxt = (w_sent_inc == c_frame_pixels) ? c_st_done : c_st_send;
                end
            end
            c_st_done: begin
                frame_done_out = 1'b1;
                w_state_nxt    = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        if (frame_start_in) begin
            w_state_nxt = c_st_ptr_rst;
        end
    end

    // Sequencing counters, output nibble and strobe level. The strobe is a
    // level that only reset clears; an aborted frame leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_cnt  <= '0;
            r_hold_cnt <= '0;
            r_sent     <= '0;
            r_nibble   <= '0;
            r_strobe   <= 1'b0;
        end else if (frame_start_in) begin
            r_ptr_cnt <= '0;
            r_sent    <= '0;
        end else begin
            case (r_state)
                c_st_ptr_rst: begin
                    r_ptr_cnt <= r_ptr_cnt + c_pcnt_one;
                end
                c_st_send: begin
                    if (w_fifo_nempty) begin
                        r_nibble <= r_fifo_mem[r_rd_ptr];
                    end
                end
                c_st_toggle: begin
                    r_strobe   <= ~r_strobe;
                    r_hold_cnt <= c_hcnt_one;
                end
                c_st_hold: begin
                    if (r_hold_cnt < c_hold_min) begin
                        r_hold_cnt <= r_hold_cnt + c_hcnt_one;
                    end
                    if (w_hold_ok) begin
                        r_sent <= w_sent_inc;
                    end
                end
                default: begin
                    r_ptr_cnt <= r_ptr_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_pixel_writer
// Brief    : Directed bench for fb_pixel_writer with a nibble scoreboard.
//            Accepted pixels are queued; every strobe toggle pops and checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_pixel_writer;

    localparam int FP  = 8;
    localparam int FD  = 4;
    localparam int HC  = 4;
    localparam int PRC = 8;

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       frame_start_in = 1'b0;
    logic [3:0] pixel_in       = 4'h0;
    logic       pixel_valid_in = 1'b0;
    logic       wr_ack_in      = 1'b0;
    logic       pixel_ready_out;
    logic [3:0] wr_nibble_out;
    logic       wr_strobe_out;
    logic       wr_reset_ptr_out;
    logic       busy_out;
    logic       frame_done_out;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_tog   = 0;
    int         n_done  = 0;
    int         done_cyc = 0;
    int         tog_cyc[$];
    logic [3:0] sb_q[$];
    bit         ack_en  = 1'b1;

    fb_pixel_writer #(
        .FRAME_PIXELS    (FP),
        .FIFO_DEPTH      (FD),
        .HOLD_CYCLES     (HC),
        .PTR_RESET_CYCLES(PRC)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start_in  (frame_start_in),
        .pixel_in        (pixel_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_ready_out (pixel_ready_out),
        .wr_nibble_out   (wr_nibble_out),
        .wr_strobe_out   (wr_strobe_out),
        .wr_reset_ptr_out(wr_reset_ptr_out),
        .wr_ack_in       (wr_ack_in),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter used to time-stamp strobe toggles and done pulses.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RP2040 model: registered echo of the strobe, can be frozen.
    initial forever begin
        @(posedge clk);
        if (ack_en) wr_ack_in <= wr_strobe_out;
    end

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        logic       prev_strobe;
        logic [3:0] prev_nib;
        logic [3:0] exp_nib;
        bit         skip_next;
        prev_strobe = 1'b0;
        prev_nib    = 4'h0;
        skip_next   = 1'b0;
        forever begin
            @(negedge clk);
            if (skip_next) begin
                skip_next = 1'b0;
            end else if (wr_strobe_out !== prev_strobe) begin
                n_tog++;
                tog_cyc.push_back(cyc);
                chk("sb_has_entry", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    exp_nib = sb_q.pop_front();
                    chk("nibble_at_toggle", wr_nibble_out, exp_nib);
                    chk("nibble_before_toggle", prev_nib, exp_nib);
                end
            end
            prev_strobe = wr_strobe_out;
            prev_nib    = wr_nibble_out;
            if (frame_done_out) begin
                n_done++;
                done_cyc = cyc;
            end
            if (rst) begin
                sb_q.delete();
                skip_next = 1'b1;
            end else if (frame_start_in) begin
                sb_q.delete();
            end else if (pixel_valid_in && pixel_ready_out) begin
                sb_q.push_back(pixel_in);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic count_ptr(output int n);
        n = 0;
        for (int i = 0; i < 40 && wr_reset_ptr_out; i++) begin
            n++;
            tick();
        end
    endtask

    task automatic push_pixel(input logic [3:0] p);
        bit ok;
        ok = 1'b0;
        pixel_in       = p;
        pixel_valid_in = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            ok = pixel_ready_out;
            tick();
        end
        pixel_valid_in = 1'b0;
        chk("push_accepted", 32'(ok), 1);
    endtask

    task automatic wait_toggles(input int target);
        for (int i = 0; i < 400 && n_tog < target; i++) tick();
        chk("toggle_count", n_tog, target);
    endtask

    initial begin
        int n;
        int base;
        int d0;
        int idx;

        // 1: reset with random inputs, then ready stays low in IDLE
        for (int i = 0; i < 3; i++) begin
            frame_start_in = 1'($urandom_range(0, 1));
            pixel_valid_in = 1'($urandom_range(0, 1));
            pixel_in       = 4'($urandom_range(0, 15));
            tick();
            chk("reset_outputs", {pixel_ready_out, wr_nibble_out, wr_strobe_out,
                                  wr_reset_ptr_out, busy_out, frame_done_out}, 0);
        end
        rst            = 1'b0;
        frame_start_in = 1'b0;
        pixel_valid_in = 1'b1;
        tick();
        chk("idle_ready", pixel_ready_out, 0);
        chk("idle_busy", busy_out, 0);
        tick();
        chk("idle_ready_2", pixel_ready_out, 0);
        pixel_valid_in = 1'b0;

        // 2: pointer reset length, three nibbles with 1-cycle echo
        start_frame();
        chk("busy_frame", busy_out, 1);
        count_ptr(n);
        chk("ptr_len_2", n, PRC);
        base = n_tog;
        push_pixel(4'hA);
        push_pixel(4'h5);
        push_pixel(4'hF);
        wait_toggles(base + 3);
        chk("spacing_a", tog_cyc[base + 1] - tog_cyc[base], 2 + HC);
        chk("spacing_b", tog_cyc[base + 2] - tog_cyc[base + 1], 2 + HC);
        repeat (8) tick();
        chk("sb_empty_2", sb_q.size(), 0);

        // 3: frozen ack fills the FIFO; release drains it in order
        ack_en = 1'b0;
        start_frame();
        count_ptr(n);
        chk("ptr_len_3", n, PRC);
        base = n_tog;
        idx  = 0;
        pixel_valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pixel_in = 4'(idx * 3 + 1);
            if (pixel_ready_out) idx++;
            tick();
        end
        chk("accepted_stall", idx, FD + 1);
        chk("ready_full", pixel_ready_out, 0);
        chk("toggles_stall", n_tog - base, 1);
        pixel_valid_in = 1'b0;
        ack_en = 1'b1;
        wait_toggles(base + FD + 1);
        repeat (12) tick();
        chk("no_extra_toggle", n_tog - base, FD + 1);
        chk("sb_empty_3", sb_q.size(), 0);

        // 4: full frame of FP pixels, the extra one is refused
        start_frame();
        count_ptr(n);
        base = n_tog;
        d0   = n_done;
        idx  = 0;
        for (int i = 0; i < 200 && n_done == d0; i++) begin
            pixel_valid_in = (idx < FP + 1);
            pixel_in       = 4'(idx + 2);
            if (pixel_ready_out && pixel_valid_in) idx++;
            tick();
        end
        pixel_valid_in = 1'b0;
        chk("accepted_frame", idx, FP);
        chk("toggles_frame", n_tog - base, FP);
        chk("done_count", n_done - d0, 1);
        chk("done_latency", done_cyc - tog_cyc[tog_cyc.size() - 1], HC);
        chk("busy_after_done", busy_out, 0);
        chk("ready_after_done", pixel_ready_out, 0);
        chk("sb_empty_4", sb_q.size(), 0);

        // 5: frame start during HOLD of pixel 3 aborts cleanly
        start_frame();
        count_ptr(n);
        base = n_tog;
        d0   = n_done;
        for (int p = 0; p < 5; p++) push_pixel(4'(p + 9));
        wait_toggles(base + 3);
        chk("busy_in_hold", busy_out, 1);
        start_frame();
        count_ptr(n);
        chk("ptr_len_abort", n, PRC);
        repeat (20) tick();
        chk("no_toggle_after_abort", n_tog - base, 3);
        chk("no_done_abort", n_done - d0, 0);
        chk("busy_abort", busy_out, 1);
        push_pixel(4'h6);
        push_pixel(4'h7);
        wait_toggles(base + 5);
        repeat (8) tick();
        chk("sb_empty_5", sb_q.size(), 0);

        // 6: reset while in TOGGLE with strobe high
        if (wr_strobe_out == 1'b0) begin
            push_pixel(4'h3);
            wait_toggles(n_tog + 1);
            repeat (8) tick();
        end
        chk("strobe_pre_rst", wr_strobe_out, 1);
        push_pixel(4'h8);
        push_pixel(4'h9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_strobe", wr_strobe_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", pixel_ready_out, 0);
        chk("rst_nibble", wr_nibble_out, 0);
        base = n_tog;
        start_frame();
        count_ptr(n);
        chk("ptr_len_6", n, PRC);
        repeat (20) tick();
        chk("fifo_empty_after_rst", n_tog - base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
